mac_accum: RTL

- Downstream stage of the 8x8 unsigned multiplier. Takes its 16-bit product stream and accumulates a run-time-programmed number of products into one dot-product sum.
- Presents the sum to the next stage, such as the register/host interface, through a valid/ready handshake.
- Completes the multiply-accumulate datapath of the IP.

---
 rtl/mac_pkg.sv | 11 +
 rtl/mac_accum.sv | 106 ++++++++++
 2 files changed

// File: rtl/mac_pkg.sv
// Shared constants for the multiply-accumulate datapath: FSM state codes
// and the product width produced by the upstream 8x8 multiplier.
package mac_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int PROD_W = 16;

endpackage

// File: rtl/mac_accum.sv
// Accumulates a programmed number of unsigned products into one sum and
// hands the result downstream over a valid/ready handshake. All outputs
// come straight from flops; the status flags are loaded from the next state.
module mac_accum
   import mac_pkg::*;
#(
   parameter int LEN_W = 16,
   parameter int ACC_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [PROD_W-1:0] prod_i,
   input  logic              prod_valid_i,
   output logic              prod_ready_o,
   output logic [ACC_W-1:0]  sum_o,
   output logic              sum_valid_o,
   input  logic              sum_ready_i,
   output logic              busy_o,
   output logic              ovf_o
);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [LEN_W-1:0] remaining;
   logic             transfer;
   logic             last;
   logic [ACC_W:0]   add_res;

   // Unsigned add of a zero-extended product; the top bit is the carry out.
   function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] acc,
                                                input logic [PROD_W-1:0] prod);
      return {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
   endfunction

   // prod_ready_o is 1 exactly while in ACCUM, so a valid product there is a transfer.
   assign transfer = (state == ST_ACCUM) && prod_valid_i;
   assign last     = transfer && (remaining == LEN_W'(1));
   assign add_res  = add_carry(sum_o, prod_i);

   // Next-state logic; start is honoured only from IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start_i) begin
               state_nxt = (len_i != '0) ? ST_ACCUM : ST_DONE;
            end
         end
         ST_ACCUM: begin
            if (last) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (sum_ready_i) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Registered handshake/status flags, decoded from the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_ready_o <= 1'b0;
         sum_valid_o  <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         prod_ready_o <= (state_nxt == ST_ACCUM);
         sum_valid_o  <= (state_nxt == ST_DONE);
         busy_o       <= (state_nxt != ST_IDLE);
      end
   end

   // Accumulator, remaining count and sticky overflow; held on bubbles and in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_o     <= '0;
         remaining <= '0;
         ovf_o     <= 1'b0;
      end else if ((state == ST_IDLE) && start_i) begin
         sum_o     <= '0;
         remaining <= len_i;
         ovf_o     <= 1'b0;
      end else if (transfer) begin
         sum_o     <= add_res[ACC_W-1:0];
         remaining <= remaining - LEN_W'(1);
         if (add_res[ACC_W]) begin
            ovf_o <= 1'b1;
         end
      end
   end

endmodule
